// File: rtl/ram_port_master.sv
// Initiator for a single-port RAM: valid/ready request in, registered RAM pins out,
// read data returned on a valid/ready response port after the RAM read latency.
module ram_port_master #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int RD_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int CNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RESP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_cnt_done;

    assign req_ready  = (r_state == S_IDLE);
    assign w_accept   = req_valid & req_ready;
    assign w_cnt_done = (r_cnt == CNT_W'(RD_LAT));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = req_we ? S_WRITE : S_READ;
                end
            end
            S_WRITE: w_next = S_IDLE;
            S_READ: begin
                if (w_cnt_done) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // RAM pins and response registers; ram_addr is held through the whole read
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_data  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            r_cnt     <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        ram_addr <= req_addr;
                        ram_data <= req_wdata;
                        ram_we   <= req_we;
                        r_cnt    <= '0;
                    end
                end
                S_WRITE: ram_we <= 1'b0;
                S_READ: begin
                    if (w_cnt_done) begin
                        rsp_rdata <= ram_q;
                        rsp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ram_we <= 1'b0;
            endcase
        end
    end

endmodule
